// File: rtl/sprite_mem_writer.sv
// Sprite attribute shadow table. Entries are staged at any time while the block is idle.
// On vblank the dirty entries are flushed to the sprite register bus, one byte per granted cycle.
module sprite_mem_writer #(
  parameter int NUM_SPRITES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stage_valid,
  output logic        stage_ready,
  input  logic [2:0]  stage_idx,
  input  logic [7:0]  stage_x,
  input  logic [7:0]  stage_y,
  input  logic [7:0]  stage_num_flip,
  input  logic [7:0]  stage_palette,
  input  logic        vblank_start,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] RAM_addr,
  output logic        wr_en,
  output logic [7:0]  sprite_RAM_dout,
  output logic        busy,
  output logic        flush_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_idx;
  logic [1:0]             r_byte;
  logic [NUM_SPRITES-1:0] r_dirty;
  logic [7:0]             r_num_flip [NUM_SPRITES];
  logic [7:0]             r_palette  [NUM_SPRITES];
  logic [7:0]             r_x        [NUM_SPRITES];
  logic [7:0]             r_y        [NUM_SPRITES];

  logic                   w_stage_acc;
  logic                   w_write;
  logic [NUM_SPRITES-1:0] w_rest;
  logic [15:0]            w_addr;
  logic [7:0]             w_data;

  // Lowest-numbered set bit; callers guarantee at least one bit is set.
  function automatic logic [2:0] first_dirty(input logic [NUM_SPRITES-1:0] d);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (d[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign busy        = (r_state != S_IDLE);
  assign stage_ready = !busy;
  assign w_stage_acc = stage_valid && stage_ready;
  assign bus_req     = (r_state == S_REQ) || (r_state == S_WRITE);
  assign wr_en       = (r_state == S_WRITE) && bus_gnt;
  assign w_write     = wr_en;
  assign flush_done  = (r_state == S_DONE);
  assign overrun     = vblank_start && busy;

  // Entries below r_idx are already written, so the remaining dirty set is the next work list.
  assign w_rest = r_dirty & ~({{(NUM_SPRITES-1){1'b0}}, 1'b1} << r_idx);

  // Address and data are a pure decode of the byte pointer, so they hold whenever the pointer stalls.
  always_comb begin
    w_addr = (r_byte[1] ? 16'h5060 : 16'h4FF0) + {12'd0, r_idx, r_byte[0]};
    case (r_byte)
      2'd0:    w_data = r_num_flip[r_idx];
      2'd1:    w_data = r_palette[r_idx];
      2'd2:    w_data = r_x[r_idx];
      default: w_data = r_y[r_idx];
    endcase
    if (r_state == S_IDLE) begin
      RAM_addr        = 16'd0;
      sprite_RAM_dout = 8'd0;
    end else begin
      RAM_addr        = w_addr;
      sprite_RAM_dout = w_data;
    end
  end

  // Shadow table, dirty bits and the flush state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_byte  <= 2'd0;
      r_dirty <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_num_flip[i] <= 8'd0;
        r_palette[i]  <= 8'd0;
        r_x[i]        <= 8'd0;
        r_y[i]        <= 8'd0;
      end
    end else begin
      if (w_stage_acc) begin
        r_num_flip[stage_idx] <= stage_num_flip;
        r_palette[stage_idx]  <= stage_palette;
        r_x[stage_idx]        <= stage_x;
        r_y[stage_idx]        <= stage_y;
        r_dirty[stage_idx]    <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_byte <= 2'd0;
          if (vblank_start && ((|r_dirty) || w_stage_acc)) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_byte <= 2'd0;
          r_idx  <= first_dirty(r_dirty);
          if (bus_gnt) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_write) begin
            if (r_byte == 2'd3) begin
              r_dirty[r_idx] <= 1'b0;
              r_byte         <= 2'd0;
              if (|w_rest) begin
                r_idx <= first_dirty(w_rest);
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_byte <= r_byte + 2'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mem_writer.sv
// Self-checking bench for sprite_mem_writer: directed scenarios plus randomized staging and grant
// patterns, checked against a table-level model of the expected write sequence.
module tb_sprite_mem_writer;

  logic        clk;
  logic        rst_n;
  logic        stage_valid;
  logic        stage_ready;
  logic [2:0]  stage_idx;
  logic [7:0]  stage_x;
  logic [7:0]  stage_y;
  logic [7:0]  stage_num_flip;
  logic [7:0]  stage_palette;
  logic        vblank_start;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] RAM_addr;
  logic        wr_en;
  logic [7:0]  sprite_RAM_dout;
  logic        busy;
  logic        flush_done;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_nf  [8];
  logic [7:0] m_pal [8];
  logic [7:0] m_x   [8];
  logic [7:0] m_y   [8];
  bit         m_dirty [8];
  logic [23:0] exp_q [$];

  sprite_mem_writer #(.NUM_SPRITES(8)) dut (
    .clk(clk), .rst_n(rst_n), .stage_valid(stage_valid), .stage_ready(stage_ready),
    .stage_idx(stage_idx), .stage_x(stage_x), .stage_y(stage_y),
    .stage_num_flip(stage_num_flip), .stage_palette(stage_palette),
    .vblank_start(vblank_start), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .RAM_addr(RAM_addr), .wr_en(wr_en), .sprite_RAM_dout(sprite_RAM_dout),
    .busy(busy), .flush_done(flush_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_nf[i] = 8'd0; m_pal[i] = 8'd0; m_x[i] = 8'd0; m_y[i] = 8'd0; m_dirty[i] = 1'b0;
    end
  endtask

  task automatic drive_stage(input logic [2:0] idx, input logic [7:0] nf, input logic [7:0] pal,
                             input logic [7:0] x, input logic [7:0] y);
    stage_valid = 1'b1; stage_idx = idx; stage_num_flip = nf;
    stage_palette = pal; stage_x = x; stage_y = y;
    m_nf[idx] = nf; m_pal[idx] = pal; m_x[idx] = x; m_y[idx] = y; m_dirty[idx] = 1'b1;
  endtask

  task automatic do_stage(input logic [2:0] idx, input logic [7:0] nf, input logic [7:0] pal,
                          input logic [7:0] x, input logic [7:0] y);
    tick();
    drive_stage(idx, nf, pal, x, y);
    #1;
    chk("stage_ready", {31'd0, stage_ready}, 32'd1);
    tick();
    stage_valid = 1'b0;
  endtask

  task automatic stage_rand(input logic [2:0] idx);
    do_stage(idx, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Every dirty entry, ascending, contributes four writes at fixed register addresses.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (m_dirty[i]) begin
        exp_q.push_back({16'h4FF0 + 16'(2 * i), m_nf[i]});
        exp_q.push_back({16'h4FF1 + 16'(2 * i), m_pal[i]});
        exp_q.push_back({16'h5060 + 16'(2 * i), m_x[i]});
        exp_q.push_back({16'h5061 + 16'(2 * i), m_y[i]});
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  // mode 0: grant held high; 1: grant dropped 3 cycles after the 2nd write; 2: random grant.
  task automatic run_flush(input int mode, input int ovr_cyc, input bit stage_with, input string tag);
    int n; int writes; int done_cnt; int done_cyc; int drop; bit dropped;
    tick();
    vblank_start = 1'b1;
    bus_gnt = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stage_with) drive_stage(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    build_expected();
    n = exp_q.size() / 4;
    #1;
    chk({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "/idle_ready"}, {31'd0, stage_ready}, 32'd1);
    chk({tag, "/idle_overrun"}, {31'd0, overrun}, 32'd0);
    writes = 0; done_cnt = 0; done_cyc = 0; drop = 0; dropped = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      vblank_start = (cyc == ovr_cyc);
      stage_valid  = 1'b0;
      if (mode == 1 && writes == 2 && !dropped) begin drop = 3; dropped = 1'b1; end
      if (drop > 0) begin bus_gnt = 1'b0; drop--; end
      else if (mode == 2) bus_gnt = ($urandom_range(0, 3) != 0);
      else bus_gnt = 1'b1;
      #1;
      if (cyc == 1) chk({tag, "/bus_req_start"}, {31'd0, bus_req}, {31'd0, n != 0});
      if (cyc == ovr_cyc) begin
        chk({tag, "/overrun"}, {31'd0, overrun}, {31'd0, n != 0});
        chk({tag, "/ready_busy"}, {31'd0, stage_ready}, {31'd0, n == 0});
      end else begin
        chk({tag, "/no_overrun"}, {31'd0, overrun}, 32'd0);
      end
      if (mode == 1 && !bus_gnt && exp_q.size() > 0) begin
        chk({tag, "/stall_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "/stall_addr"}, {16'd0, RAM_addr}, {16'd0, exp_q[0][23:8]});
        chk({tag, "/stall_data"}, {24'd0, sprite_RAM_dout}, {24'd0, exp_q[0][7:0]});
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk({tag, "/extra_write"}, {16'd0, RAM_addr}, 32'hFFFF_FFFF);
        end else begin
          chk({tag, "/addr"}, {16'd0, RAM_addr}, {16'd0, exp_q[0][23:8]});
          chk({tag, "/data"}, {24'd0, sprite_RAM_dout}, {24'd0, exp_q[0][7:0]});
          void'(exp_q.pop_front());
        end
        writes++;
      end
      if (flush_done) begin done_cnt++; done_cyc = cyc; end
      if (n == 0 && cyc >= 6) break;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    vblank_start = 1'b0;
    chk({tag, "/write_count"}, writes, 4 * n);
    chk({tag, "/done_count"}, done_cnt, (n != 0) ? 1 : 0);
    if (mode == 0 && n != 0) chk({tag, "/done_cycle"}, done_cyc, 4 * n + 2);
    chk({tag, "/end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int writes;
    rst_n = 1'b0; stage_valid = 1'b0; stage_idx = 3'd0; stage_x = 8'd0; stage_y = 8'd0;
    stage_num_flip = 8'd0; stage_palette = 8'd0; vblank_start = 1'b1; bus_gnt = 1'b1;
    model_clear();
    #13;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, stage_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_addr", {16'd0, RAM_addr}, 32'd0);
    chk("rst_dout", {24'd0, sprite_RAM_dout}, 32'd0);
    chk("rst_done", {31'd0, flush_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    vblank_start = 1'b0;
    #10 rst_n = 1'b1;

    run_flush(0, 0, 1'b0, "no_dirty");

    do_stage(3'd2, 8'hA5, 8'h03, 8'h40, 8'h50);
    run_flush(0, 0, 1'b0, "single_idx2");

    for (int i = 0; i < 8; i++) stage_rand(3'(i));
    run_flush(0, 0, 1'b0, "all_eight");

    stage_rand(3'd0);
    do_stage(3'd0, 8'h11, 8'h22, 8'h77, 8'h33);
    run_flush(0, 0, 1'b0, "restage");

    stage_rand(3'd1);
    stage_rand(3'd5);
    run_flush(1, 0, 1'b0, "gnt_drop");

    stage_rand(3'd3);
    stage_rand(3'd6);
    run_flush(0, 3, 1'b0, "overrun");

    run_flush(0, 0, 1'b1, "stage_with_vblank");

    stage_rand(3'd4);
    stage_rand(3'd7);
    tick();
    vblank_start = 1'b1; bus_gnt = 1'b1;
    writes = 0;
    for (int cyc = 0; cyc < 40 && writes < 5; cyc++) begin
      tick();
      vblank_start = 1'b0;
      #1;
      if (wr_en) writes++;
    end
    chk("rst_mid_writes", writes, 5);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    #10 rst_n = 1'b1;
    model_clear();
    run_flush(0, 0, 1'b0, "post_reset");

    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) stage_rand(3'($urandom));
      run_flush(2, 0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_mem_writer.md
SPRITE_MEM_WRITER -- requirements
Module: sprite_mem_writer

Interface
REQ-001 Parameter NUM_SPRITES, default 8, is the number of sprite slots; only 8 is supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 stage_valid  in  1  staging entry offered this cycle.
REQ-006 stage_ready  out  1  staging entry accepted when stage_valid && stage_ready.
REQ-007 stage_idx  in  3  sprite slot being staged.
REQ-008 stage_x, stage_y, stage_num_flip, stage_palette  in  8 each  sprite attribute bytes (num_flip = {num[5:0], xflip, yflip}).
REQ-009 vblank_start  in  1  one-cycle pulse that requests a flush.
REQ-010 bus_req  out  1  request for the sprite register write bus.
REQ-011 bus_gnt  in  1  bus granted; may drop at any cycle.
REQ-012 RAM_addr  out  16  sprite register write address.
REQ-013 wr_en  out  1  write strobe; one byte written per cycle asserted.
REQ-014 sprite_RAM_dout  out  8  write data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 flush_done  out  1  one-cycle pulse at the end of a flush.
REQ-017 overrun  out  1  one-cycle pulse when vblank_start arrives while busy.

Function
REQ-018 The shadow table shall hold 8 entries of 4 bytes plus one dirty bit per entry.
REQ-019 An accepted stage transfer shall overwrite all 4 bytes of entry stage_idx and set its dirty bit; re-staging a dirty entry before a flush keeps only the newest data.
REQ-020 stage_ready shall equal !busy.
REQ-021 FSM states: IDLE, REQ, WRITE, DONE.
REQ-022 IDLE -> REQ on vblank_start when at least one dirty bit is set. With no dirty bit set, vblank_start is ignored: no bus_req and no flush_done.
REQ-023 bus_req shall be high in REQ and WRITE, and low in IDLE and DONE.
REQ-024 REQ -> WRITE on the cycle after bus_gnt is sampled high.
REQ-025 wr_en = (state == WRITE) && bus_gnt, combinational from bus_gnt.
- If bus_gnt is low in WRITE, the FSM stalls: the byte pointer holds and RAM_addr/sprite_RAM_dout hold their values.
REQ-026 Dirty entries shall be written in ascending index order; clean entries are skipped with no idle cycle between entries.
REQ-027 Per entry i, the byte order and addresses shall be:
- num_flip -> 16'h4FF0 + 2i
- palette -> 16'h4FF1 + 2i
- x -> 16'h5060 + 2i
- y -> 16'h5061 + 2i
REQ-028 An entry's dirty bit shall clear on the cycle its 4th byte is written.
- After the last dirty entry, WRITE -> DONE.
- DONE asserts flush_done for one cycle, then -> IDLE.
REQ-029 Total writes per flush shall be 4 × (number of dirty entries at flush start).
- With bus_gnt held high, the flush occupies 1 REQ cycle, then 4N WRITE cycles, then 1 DONE cycle.
REQ-030 When vblank_start arrives while busy, it shall assert overrun for that cycle and shall not queue a second flush.
REQ-031 When vblank_start and an accepted stage transfer occur in the same IDLE cycle, the staged entry shall be included in the flush.
REQ-032 When wr_en is low, RAM_addr and sprite_RAM_dout are don't-care but stable; they are driven to 0 in IDLE.

Reset
REQ-033 While rst_n is low, the block shall be in IDLE with all dirty bits and table bytes at 0, and all outputs at 0 except stage_ready = 1.
REQ-034 Reset asserted mid-flush shall abort immediately: no further wr_en, no flush_done, and all dirty bits cleared.

Verification
REQ-035 Stage idx 2 (num_flip 8'hA5, palette 8'h03, x 8'h40, y 8'h50), hold bus_gnt = 1, pulse vblank_start -> bus_req the next cycle, then 4 consecutive writes: 4FF4/A5, 4FF5/03, 5064/40, 5065/50; flush_done 1 cycle later.
REQ-036 Stage all 8 entries, bus_gnt = 1, vblank_start -> exactly 32 writes over addresses 4FF0..4FFF and 5060..506F in entry order; flush_done at cycle 34 after vblank_start.
REQ-037 Stage idx 0, then idx 0 again with x 8'h77, flush -> only 4 writes, with 16'h5060 written as 8'h77.
REQ-038 Drop bus_gnt for 3 cycles after the 2nd write -> wr_en low for 3 cycles, address and data held, then the sequence resumes at the 3rd byte with no write lost or duplicated.
REQ-039 With no dirty entries, vblank_start -> no bus_req. Then, with a flush in progress, a second vblank_start -> overrun pulse, stage_ready = 0, and a single flush_done.
REQ-040 Assert rst_n = 0 after the 5th write of a 2-entry flush -> wr_en and bus_req fall immediately; a subsequent vblank_start with no restaging produces no writes.
